i2c_xfer_seq: RTL and testbench

Transaction sequencer that sits between a host register interface and the byte-level I2C master engine. It turns one host command (device address, register address, read/write, one data byte) into the full bus sequence.
- Write: START, ADDR+W, REG, DATA, STOP.
- Read: START, ADDR+W, REG, repeated START, ADDR+R, DATA, STOP.
It drives the engine's start/stop/tx_on/rx_on controls, checks ACKs, enforces a per-operation timeout and returns read data plus a status code.

---
 rtl/i2c_xfer_seq_if.sv | 35 +++
 rtl/i2c_xfer_seq.sv | 163 ++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_xfer_seq_if.sv
// Host command/response and byte-engine control bundle for i2c_xfer_seq.
// The slave modport is the sequencer's view; master is the host/engine side.
interface i2c_xfer_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdata;
    logic       eng_start;
    logic       eng_stop;
    logic       eng_tx_on;
    logic       eng_rx_on;
    logic [7:0] eng_tx_byte;
    logic       eng_busy;
    logic       eng_ack;
    logic [7:0] eng_rx_byte;

    modport slave (
        input  cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
        input  eng_busy, eng_ack, eng_rx_byte,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        output eng_start, eng_stop, eng_tx_on, eng_rx_on, eng_tx_byte
    );

    modport master (
        output cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
        output eng_busy, eng_ack, eng_rx_byte,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        input  eng_start, eng_stop, eng_tx_on, eng_rx_on, eng_tx_byte
    );
endinterface

// File: rtl/i2c_xfer_seq.sv
// Turns one host register read/write into START/byte/STOP operations on the I2C byte engine.
// Define I2C_RETRY_EN to retry the whole transaction on address NACK up to RETRY_MAX times.
module i2c_xfer_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter int unsigned RETRY_MAX   = 2
) (
    input logic           clk,
    input logic           resetn,
    i2c_xfer_seq_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StStart, StAddrW, StReg, StDataW, StRstart, StAddrR, StDataR, StStop, StDone
    } state_e;
    // PhReq: control high until busy seen; PhWait: wait for busy low; PhHold: timeout gap
    typedef enum logic [1:0] {PhReq, PhWait, PhHold} phase_e;

    localparam logic [1:0] ErrOk   = 2'b00;
    localparam logic [1:0] ErrAddr = 2'b01;
    localparam logic [1:0] ErrData = 2'b10;
    localparam logic [1:0] ErrTmo  = 2'b11;

    state_e      state_q, state_d, next_op;
    phase_e      phase_q, phase_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  err_q, err_d, err_new;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q, wdata_q;
    logic        accept, op_done, tmo_hit, retry, req;

    assign accept  = bus.cmd_valid && (state_q == StIdle);
    assign op_done = (phase_q == PhWait) && !bus.eng_busy;
    assign tmo_hit = (TIMEOUT_CYC != 16'd0) && (tmo_q == TIMEOUT_CYC - 16'd1);

`ifdef I2C_RETRY_EN
    localparam logic [1:0] RetryMax = RETRY_MAX[1:0];
    logic [1:0] retry_q;

    assign retry = (state_q == StStop) && op_done && (err_q == ErrAddr) && (retry_q < RetryMax);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retry_q <= 2'd0;
        end else if (accept) begin
            retry_q <= 2'd0;
        end else if (retry) begin
            retry_q <= retry_q + 2'd1;
        end
    end
`else
    assign retry = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
        end else if (accept) begin
            rd_q    <= bus.cmd_rd;
            dev_q   <= bus.cmd_dev;
            reg_q   <= bus.cmd_reg;
            wdata_q <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            phase_q <= PhReq;
            tmo_q   <= 16'd0;
            err_q   <= ErrOk;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        err_new = ErrOk;
        next_op = StStop;

        // Successor of the current operation once the engine reports completion
        unique case (state_q)
            StStart:  next_op = StAddrW;
            StAddrW:  if (bus.eng_ack) next_op = StReg; else err_new = ErrAddr;
            StReg: begin
                if (!bus.eng_ack) err_new = ErrData;
                else if (rd_q)    next_op = StRstart;
                else              next_op = StDataW;
            end
            StDataW:  if (!bus.eng_ack) err_new = ErrData;
            StRstart: next_op = StAddrR;
            StAddrR:  if (bus.eng_ack) next_op = StDataR; else err_new = ErrAddr;
            StStop:   next_op = retry ? StStart : StDone;
            default:  next_op = StStop;
        endcase

        if (state_q == StIdle) begin
            if (accept) begin
                state_d = StStart;
                phase_d = PhReq;
                tmo_d   = 16'd0;
                err_d   = ErrOk;
            end
        end else if (state_q == StDone) begin
            state_d = StIdle;
        end else if (phase_q == PhHold) begin
            state_d = StStop;
            phase_d = PhReq;
            tmo_d   = 16'd0;
        end else if (op_done) begin
            state_d = next_op;
            phase_d = PhReq;
            tmo_d   = 16'd0;
            if (err_q == ErrOk) err_d = err_new;
            if (state_q == StDataR) rdata_d = bus.eng_rx_byte;
            if (retry) err_d = ErrOk;
        end else if (tmo_hit) begin
            // First recorded error wins; a STOP that hangs goes straight to DONE
            tmo_d = 16'd0;
            if (err_q == ErrOk) err_d = ErrTmo;
            if (state_q == StStop) state_d = StDone;
            else                   phase_d = PhHold;
        end else begin
            tmo_d = tmo_q + 16'd1;
            if ((phase_q == PhReq) && bus.eng_busy) phase_d = PhWait;
        end
    end

    assign req           = (phase_q == PhReq);
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.eng_start = req && ((state_q == StStart) || (state_q == StRstart));
    assign bus.eng_stop  = req && (state_q == StStop);
    assign bus.eng_tx_on = req && ((state_q == StAddrW) || (state_q == StReg) ||
                                   (state_q == StDataW) || (state_q == StAddrR));
    assign bus.eng_rx_on = req && (state_q == StDataR);

    always_comb begin
        bus.eng_tx_byte = 8'h00;
        case (state_q)
            StAddrW: bus.eng_tx_byte = {dev_q, 1'b0};
            StReg:   bus.eng_tx_byte = reg_q;
            StDataW: bus.eng_tx_byte = wdata_q;
            StAddrR: bus.eng_tx_byte = {dev_q, 1'b1};
            default: bus.eng_tx_byte = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Scoreboard bench for i2c_xfer_seq: engine model, bus-operation monitor and response monitor.
module tb_i2c_xfer_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    i2c_xfer_seq_if bus ();

    i2c_xfer_seq #(
        .TIMEOUT_CYC(16'd100),
        .RETRY_MAX  (2)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

`ifdef I2C_RETRY_EN
    localparam int Tries = 3;
`else
    localparam int Tries = 1;
`endif
    localparam logic [1:0] OpStart = 2'd0;
    localparam logic [1:0] OpStop  = 2'd1;
    localparam logic [1:0] OpTx    = 2'd2;
    localparam logic [1:0] OpRx    = 2'd3;

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;
    int t_cycle = 0;
    int t_tx_rise = 0;
    int t_stop_rise = 0;
    logic [9:0]  exp_ops[$];
    logic [10:0] exp_rsp[$];
    logic [7:0]  nack_byte, hang_byte, rx_val;
    logic        nack_en, hang_en, hang_release;

    always @(posedge clk) t_cycle <= t_cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic void push_op(input logic [1:0] t, input logic [7:0] b);
        exp_ops.push_back({t, b});
    endfunction

    function automatic void push_rsp(input logic chk, input logic [1:0] e, input logic [7:0] d);
        exp_rsp.push_back({chk, e, d});
    endfunction

    // Byte-engine model: busy for a few cycles per request, optional NACK/hang on a chosen byte
    initial begin : engine
        logic hang, ack_v;
        int   n;
        bus.eng_busy    = 1'b0;
        bus.eng_ack     = 1'b0;
        bus.eng_rx_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && (bus.eng_start || bus.eng_stop || bus.eng_tx_on || bus.eng_rx_on)) begin
                hang  = hang_en && bus.eng_tx_on && (bus.eng_tx_byte == hang_byte);
                ack_v = !(nack_en && bus.eng_tx_on && (bus.eng_tx_byte == nack_byte));
                bus.eng_busy = 1'b1;
                n = 0;
                while (resetn && ((n < 3) || (hang && !hang_release))) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                bus.eng_ack     = ack_v;
                bus.eng_rx_byte = rx_val;
                bus.eng_busy    = 1'b0;
            end
        end
    end

    // Every rising engine control is one operation; compare against the expected sequence
    initial begin : bus_mon
        logic [3:0] ctl, prev, rise;
        logic [9:0] ev, exp;
        prev = 4'b0;
        forever begin
            @(negedge clk);
            ctl  = {bus.eng_start, bus.eng_stop, bus.eng_tx_on, bus.eng_rx_on};
            rise = ctl & ~prev;
            if ($countones(ctl) > 1) begin
                checks++;
                errors++;
                $display("FAIL ctl_onehot: got controls %b, required at most one high", ctl);
            end
            if (rise != 4'b0) begin
                if (rise[3]) begin
                    ev = {OpStart, 8'h00};
                end else if (rise[2]) begin
                    ev = {OpStop, 8'h00};
                    t_stop_rise = t_cycle;
                end else if (rise[1]) begin
                    ev = {OpTx, bus.eng_tx_byte};
                    t_tx_rise = t_cycle;
                end else begin
                    ev = {OpRx, 8'h00};
                end
                checks++;
                if (exp_ops.size() == 0) begin
                    errors++;
                    $display("FAIL op_seq: got op %0d byte %h, required no operation",
                             ev[9:8], ev[7:0]);
                end else begin
                    exp = exp_ops.pop_front();
                    if (ev !== exp) begin
                        errors++;
                        $display("FAIL op_seq: got op %0d byte %h, required op %0d byte %h",
                                 ev[9:8], ev[7:0], exp[9:8], exp[7:0]);
                    end
                end
            end
            prev = ctl;
        end
    end

    initial begin : rsp_mon
        logic [10:0] exp;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rsp_seen++;
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_err %b, required no response",
                             bus.rsp_err);
                end else begin
                    exp = exp_rsp.pop_front();
                    if (bus.rsp_err !== exp[9:8]) begin
                        errors++;
                        $display("FAIL rsp_err: got %b, required %b", bus.rsp_err, exp[9:8]);
                    end
                    if (exp[10]) begin
                        checks++;
                        if (bus.rsp_rdata !== exp[7:0]) begin
                            errors++;
                            $display("FAIL rsp_rdata: got %h, required %h",
                                     bus.rsp_rdata, exp[7:0]);
                        end
                    end
                end
                check("cmd_ready_with_rsp", 32'(bus.cmd_ready), 32'd0);
                @(negedge clk);
                check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
                check("cmd_ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
            end
        end
    end

    task automatic send(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = rd;
        bus.cmd_dev   = dev;
        bus.cmd_reg   = rg;
        bus.cmd_wdata = wd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_xfer(input string name, input int budget);
        int start, n;
        start = rsp_seen;
        n = 0;
        while ((rsp_seen == start) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        check({name, "_rsp_seen"}, 32'(rsp_seen != start), 32'd1);
        repeat (4) @(posedge clk);
        check({name, "_ops_left"}, 32'(exp_ops.size()), 32'd0);
        check({name, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
        exp_ops.delete();
        exp_rsp.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int seen0, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_rd    = 1'b0;
        bus.cmd_dev   = 7'd0;
        bus.cmd_reg   = 8'd0;
        bus.cmd_wdata = 8'd0;
        nack_en = 1'b0; hang_en = 1'b0; hang_release = 1'b0;
        nack_byte = 8'h00; hang_byte = 8'h00; rx_val = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_eng_ctl", 32'({bus.eng_start, bus.eng_stop, bus.eng_tx_on, bus.eng_rx_on}),
              32'd0);
        check("rst_tx_byte", 32'(bus.eng_tx_byte), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Plain write
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hA0); push_op(OpTx, 8'h10);
        push_op(OpTx, 8'hA5); push_op(OpStop, 8'h00);
        push_rsp(1'b0, 2'b00, 8'h00);
        send(1'b0, 7'h50, 8'h10, 8'hA5);
        finish_xfer("write", 300);

        // Plain read
        rx_val = 8'h71;
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hD0); push_op(OpTx, 8'h75);
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hD1); push_op(OpRx, 8'h00);
        push_op(OpStop, 8'h00);
        push_rsp(1'b1, 2'b00, 8'h71);
        send(1'b1, 7'h68, 8'h75, 8'h00);
        finish_xfer("read", 300);

        // Address NACK in ADDR_W
        nack_en = 1'b1; nack_byte = 8'h78;
        for (int i = 0; i < Tries; i++) begin
            push_op(OpStart, 8'h00); push_op(OpTx, 8'h78); push_op(OpStop, 8'h00);
        end
        push_rsp(1'b0, 2'b01, 8'h00);
        send(1'b0, 7'h3C, 8'h01, 8'h02);
        finish_xfer("addr_nack_w", 400);

        // Address NACK in ADDR_R
        nack_byte = 8'hD1;
        for (int i = 0; i < Tries; i++) begin
            push_op(OpStart, 8'h00); push_op(OpTx, 8'hD0); push_op(OpTx, 8'h75);
            push_op(OpStart, 8'h00); push_op(OpTx, 8'hD1); push_op(OpStop, 8'h00);
        end
        push_rsp(1'b0, 2'b01, 8'h00);
        send(1'b1, 7'h68, 8'h75, 8'h00);
        finish_xfer("addr_nack_r", 600);

        // REG NACK on a write
        nack_byte = 8'h33;
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hA0); push_op(OpTx, 8'h33);
        push_op(OpStop, 8'h00);
        push_rsp(1'b0, 2'b10, 8'h00);
        send(1'b0, 7'h50, 8'h33, 8'h5A);
        finish_xfer("reg_nack", 300);

        // DATA NACK on a write
        nack_byte = 8'h5A;
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hA0); push_op(OpTx, 8'h10);
        push_op(OpTx, 8'h5A); push_op(OpStop, 8'h00);
        push_rsp(1'b0, 2'b10, 8'h00);
        send(1'b0, 7'h50, 8'h10, 8'h5A);
        finish_xfer("data_nack", 300);
        nack_en = 1'b0;

        // Engine hangs busy in REG: abort, STOP (also hangs), err 11
        hang_en = 1'b1; hang_byte = 8'h99;
        push_op(OpStart, 8'h00); push_op(OpTx, 8'h44); push_op(OpTx, 8'h99);
        push_op(OpStop, 8'h00);
        push_rsp(1'b0, 2'b11, 8'h00);
        send(1'b0, 7'h22, 8'h99, 8'h00);
        finish_xfer("timeout", 500);
        check("timeout_stop_delay", 32'(t_stop_rise - t_tx_rise), 32'd101);
        hang_release = 1'b1;
        repeat (6) @(posedge clk);
        hang_en = 1'b0; hang_release = 1'b0;

        // Reset during DATA_R
        rx_val = 8'h3C;
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hD0); push_op(OpTx, 8'h75);
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hD1); push_op(OpRx, 8'h00);
        seen0 = rsp_seen;
        send(1'b1, 7'h68, 8'h75, 8'h00);
        n = 0;
        while (!bus.eng_rx_on && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check("rx_on_reached", 32'(bus.eng_rx_on), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_eng_ctl",
              32'({bus.eng_start, bus.eng_stop, bus.eng_tx_on, bus.eng_rx_on}), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_eng_ctl_held",
              32'({bus.eng_start, bus.eng_stop, bus.eng_tx_on, bus.eng_rx_on}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (6) @(negedge clk);
        check("post_rst_no_rsp", 32'(rsp_seen - seen0), 32'd0);
        check("post_rst_ops_left", 32'(exp_ops.size()), 32'd0);
        exp_ops.delete();

        // Recovery write after reset
        push_op(OpStart, 8'h00); push_op(OpTx, 8'hA0); push_op(OpTx, 8'h20);
        push_op(OpTx, 8'hC3); push_op(OpStop, 8'h00);
        push_rsp(1'b0, 2'b00, 8'h00);
        send(1'b0, 7'h50, 8'h20, 8'hC3);
        finish_xfer("recover_write", 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
